// File: rtl/pcm_capture_fifo_if.sv
// Capture-path stream bundle: mixer sample strobe in, FWFT readout stream out.
// The master modport is the capture block and the slave modport is the mixer/readout side.
interface pcm_capture_fifo_if #(
  parameter int SAMPLE_W = 8
);
  logic                in_valid;
  logic [SAMPLE_W-1:0] in_data;
  logic                out_valid;
  logic [SAMPLE_W-1:0] out_data;
  logic                out_ready;

  modport master (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data
  );
endinterface

// File: rtl/pcm_capture_fifo.sv
// Mixer PCM capture: block-average 2^k strobed samples into a FWFT FIFO with drop accounting.
// Optional peak tracker is enabled by defining PCM_CAPTURE_PEAK_EN.
module pcm_capture_fifo #(
  parameter int SAMPLE_W       = 8,
  parameter int MAX_DECIM_LOG2 = 4,
  parameter int DEPTH          = 16,
  parameter int DROP_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [2:0]               dec_log2,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_ovf,
  output logic [SAMPLE_W-1:0]      peak,
  input  logic                     peak_clr,
  pcm_capture_fifo_if.master       bus
);
  localparam int AW = SAMPLE_W + MAX_DECIM_LOG2;
  localparam int CW = MAX_DECIM_LOG2 + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [2:0] KMAX = 3'(MAX_DECIM_LOG2);

  logic [AW-1:0]       acc, sum;
  logic [CW-1:0]       cnt, cnt_next;
  logic [2:0]          k_lat, k_in, k_cur;
  logic                take, done;
  logic [SAMPLE_W-1:0] res, res_d;
  logic                push_req;

  // k applies from the first sample of a block; mid-block changes wait for the next one
  always_comb begin
    k_in     = (dec_log2 > KMAX) ? KMAX : dec_log2;
    k_cur    = (cnt == '0) ? k_in : k_lat;
    take     = bus.in_valid & enable;
    cnt_next = cnt + CW'(1);
    done     = take && (cnt_next == (CW'(1) << k_cur));
    sum      = acc + AW'(bus.in_data);
    res_d    = SAMPLE_W'(sum >> k_cur);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      k_lat    <= '0;
      res      <= '0;
      push_req <= 1'b0;
    end else begin
      push_req <= done;
      if (done) res <= res_d;
      if (!enable || done) begin
        acc <= '0;
        cnt <= '0;
      end else if (take) begin
        acc <= sum;
        cnt <= cnt_next;
        if (cnt == '0) k_lat <= k_in;
      end
    end
  end

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [PW:0]         wr_ptr, rd_ptr;
  logic                full, pop, push, drop;

  assign level         = wr_ptr - rd_ptr;
  assign full          = (level == (PW+1)'(DEPTH));
  assign bus.out_valid = (level != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr[PW-1:0]] : '0;
  assign pop           = bus.out_valid & bus.out_ready;
  // At full, a same-cycle pop frees the slot the write lands in
  assign push          = push_req & (~full | pop);
  assign drop          = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= res;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Clear takes priority, then a same-cycle drop is recorded on top of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef PCM_CAPTURE_PEAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak <= '0;
    end else if (peak_clr) begin
      peak <= take ? bus.in_data : '0;
    end else if (take && (bus.in_data > peak)) begin
      peak <= bus.in_data;
    end
  end
`else
  logic peak_clr_unused;
  assign peak_clr_unused = peak_clr;
  assign peak            = '0;
`endif

endmodule

// File: tb/tb_pcm_capture_fifo.sv
// Directed bench for pcm_capture_fifo: decimation, FIFO full/drop handling, enable/reset, peak.
module tb_pcm_capture_fifo;
  logic       clk = 1'b0;
  logic       rst, enable, clr_ovf, peak_clr;
  logic [2:0] dec_log2;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_cnt, peak;
  int n_tests = 0;
  int n_fail  = 0;

`ifdef PCM_CAPTURE_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  pcm_capture_fifo_if #(.SAMPLE_W(8)) bus ();

  pcm_capture_fifo #(
    .SAMPLE_W(8), .MAX_DECIM_LOG2(4), .DEPTH(16), .DROP_W(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .dec_log2(dec_log2),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf),
    .peak(peak), .peak_clr(peak_clr), .bus(bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe sampled by the next rising edge; returns one negedge after it
  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] v3 [3];

  initial begin
    rst = 1'b1; enable = 1'b0; clr_ovf = 1'b0; peak_clr = 1'b0; dec_log2 = 3'd0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
    idle(2);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_peak", peak, 0);
    rst = 1'b0;

    // k=0 pass-through, latency of two edges
    enable = 1'b1; bus.out_ready = 1'b1;
    v3 = '{8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 3; i++) begin
      strobe(v3[i]);
      chk("k0_lat_early", bus.out_valid, 0);
      @(negedge clk);
      chk("k0_valid", bus.out_valid, 1);
      chk("k0_data", bus.out_data, v3[i]);
      idle(3);
    end
    chk("k0_level_drained", level, 0);

    // k=2 averaging
    dec_log2 = 3'd2;
    strobe(8'h01); strobe(8'h02); strobe(8'h03);
    @(negedge clk);
    chk("k2_partial", bus.out_valid, 0);
    strobe(8'h06);
    @(negedge clk);
    chk("k2_valid", bus.out_valid, 1);
    chk("k2_avg", bus.out_data, 8'h03);
    idle(2);
    for (int i = 0; i < 4; i++) strobe(8'hFF);
    @(negedge clk);
    chk("k2_ff", bus.out_data, 8'hFF);
    idle(2);

    // k=4 full scale, then clamp of k=7 to 4
    dec_log2 = 3'd4;
    for (int i = 0; i < 16; i++) strobe(8'hFF);
    @(negedge clk);
    chk("k4_ff", bus.out_data, 8'hFF);
    idle(2);
    dec_log2 = 3'd7;
    for (int i = 0; i < 15; i++) strobe(8'h08);
    @(negedge clk);
    chk("clamp_partial", bus.out_valid, 0);
    strobe(8'h08);
    @(negedge clk);
    chk("clamp_valid", bus.out_valid, 1);
    chk("clamp_data", bus.out_data, 8'h08);
    idle(2);

    // k change mid-block applies on the next block
    dec_log2 = 3'd2;
    strobe(8'h04); strobe(8'h08);
    dec_log2 = 3'd0;
    strobe(8'h0C);
    @(negedge clk);
    chk("kchg_partial", bus.out_valid, 0);
    strobe(8'h10);
    @(negedge clk);
    chk("kchg_avg", bus.out_data, 8'h0A);
    idle(2);
    strobe(8'h21);
    @(negedge clk);
    chk("kchg_pass", bus.out_data, 8'h21);
    idle(2);

    // Fill to full with drops
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) strobe(8'(i));
    idle(2);
    chk("full_level", level, 16);
    chk("full_overflow", overflow, 1);
    chk("full_drop_cnt", drop_cnt, 4);
    chk("full_head", bus.out_data, 8'h01);
    strobe(8'h55);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("full_pushpop_level", level, 16);
    chk("full_pushpop_head", bus.out_data, 8'h02);
    chk("full_pushpop_drops", drop_cnt, 4);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_drop_cnt", drop_cnt, 0);
    strobe(8'h66);
    clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("clrdrop_overflow", overflow, 1);
    chk("clrdrop_drop_cnt", drop_cnt, 1);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    bus.out_ready = 1'b1;
    idle(20);
    chk("drain_level", level, 0);

    // enable low discards partial block
    bus.out_ready = 1'b0;
    dec_log2 = 3'd3;
    for (int i = 0; i < 5; i++) strobe(8'h10);
    @(negedge clk); enable = 1'b0;
    @(negedge clk); enable = 1'b1;
    for (int i = 0; i < 7; i++) strobe(8'h40);
    @(negedge clk);
    chk("en_partial_level", level, 0);
    strobe(8'h40);
    @(negedge clk);
    chk("en_level", level, 1);
    chk("en_data", bus.out_data, 8'h40);
    bus.out_ready = 1'b1;
    idle(2);
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-block with entries queued
    dec_log2 = 3'd0;
    strobe(8'h11); strobe(8'h22); strobe(8'h33);
    @(negedge clk);
    chk("pre_rst_level", level, 3);
    dec_log2 = 3'd2;
    strobe(8'h44);
    #2 rst = 1'b1;
    #1;
    chk("arst_level", level, 0);
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_out_data", bus.out_data, 0);
    @(negedge clk); rst = 1'b0;
    dec_log2 = 3'd0;
    strobe(8'h77);
    @(negedge clk);
    chk("post_rst_level", level, 1);
    chk("post_rst_data", bus.out_data, 8'h77);

    // Peak tracker
    bus.out_ready = 1'b1;
    strobe(8'h12); strobe(8'h80); strobe(8'h33);
    chk("peak_max", peak, PK ? 8'h80 : 8'h00);
    @(negedge clk); peak_clr = 1'b1;
    @(negedge clk); peak_clr = 1'b0;
    chk("peak_clr", peak, 0);
    strobe(8'h05);
    chk("peak_after_clr", peak, PK ? 8'h05 : 8'h00);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pcm_capture_fifo.md
Name: pcm_capture_fifo

Overview:
- On-chip capture path for the voice mixer output.
- Samples the mixer PCM word on a per-frame strobe (the mix-latch slot), block-averages 2^k consecutive samples (k set at runtime), and buffers results in a FWFT FIFO.
- FIFO drains over a valid/ready stream to the SPI/debug readout.
- Replaces bench-side sampling of mix_out with a synthesizable, parametrised capture block that has overflow accounting.

Parameters:
- SAMPLE_W, 8, width of input sample and output sample (unsigned).
- MAX_DECIM_LOG2, 4, largest supported decimation exponent; accumulator width is SAMPLE_W+MAX_DECIM_LOG2.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- DROP_W, 8, width of saturating dropped-sample counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  capture enable; low discards the partial block
- in_valid  in  1  one-cycle strobe, one per mixer frame
- in_data  in  SAMPLE_W  mixer sample, sampled when in_valid=1
- dec_log2  in  3  decimation exponent k; values above MAX_DECIM_LOG2 are clamped
- out_valid  out  1  FIFO not empty
- out_data  out  SAMPLE_W  FIFO head (FWFT)
- out_ready  in  1  consumer accepts head when out_valid=1
- level  out  clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: at least one result dropped
- drop_cnt  out  DROP_W  results dropped, saturating
- clr_ovf  in  1  clears overflow and drop_cnt
- peak  out  SAMPLE_W  max input sample since clear (optional feature)
- peak_clr  in  1  clears peak (optional feature)

Behaviour:
- Reset values (rst=1, asynchronous): accumulator 0, sample counter 0, latched k 0, FIFO pointers 0, out_valid 0, out_data 0, level 0, overflow 0, drop_cnt 0, peak 0.
- The accumulator is SAMPLE_W+MAX_DECIM_LOG2 bits wide and unsigned.
  - Each accepted sample (in_valid & enable) is added to it.
  - The counter increments per accepted sample.
  - in_valid while enable=0 is ignored.
- k is latched at each block start: first sample after reset, after enable rises, or after block completion.
  - A dec_log2 change mid-block takes effect on the next block.
- Block completes on the 2^k-th accepted sample.
  - Result = (acc + that sample) >> k, truncated to SAMPLE_W. No rounding.
  - k=0 passes samples through.
  - Result is registered at edge E. Accumulator and counter clear at E.
  - FIFO write request occurs at E+1. out_valid is high from E+1 if the FIFO was empty.
  - Fixed latency: 2 clock edges from the completing in_valid to data at head.
- enable low for any cycle: accumulator and counter clear, and no partial result is pushed. FIFO contents are kept and may continue draining.
- FIFO:
  - Pop when out_valid & out_ready.
  - Push is accepted if level<DEPTH, or if level==DEPTH and a pop occurs in the same cycle.
  - Simultaneous push and pop keeps level unchanged.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.
- Drops: a push refused while full discards the new result; FIFO contents are unchanged.
  - overflow sets on the same edge.
  - drop_cnt increments, holding at 2^DROP_W-1.
- clr_ovf:
  - Clears overflow and drop_cnt on the next edge.
  - If a drop occurs in the same cycle, clear wins, then overflow=1 and drop_cnt=1 are recorded. Net result: overflow=1, drop_cnt=1.

Optional Feature:
- Macro: PCM_CAPTURE_PEAK_EN.
- Defined:
  - peak tracks the maximum in_data over accepted samples, pre-decimation, since reset or peak_clr.
  - peak_clr sets peak to the current accepted sample if one is present in that cycle, otherwise to 0.
- Undefined: peak is tied to 0, peak_clr is ignored, and no registers are inferred.

Test Plan:
- k=0, enable=1, in_data 0x10,0x20,0x30 on strobes every 6 clocks, out_ready=1 -> out_data 0x10,0x20,0x30 in order, each 2 edges after its strobe; level returns to 0.
- k=2, samples 0x01,0x02,0x03,0x06 -> single result 0x03 ((12)>>2); samples 0xFF×4 -> 0xFF (no accumulator overflow).
- k=4 and 0xFF×16 -> 0xFF. Set dec_log2=7 -> clamped to 4. Change k from 2 to 0 after 2 of 4 samples -> current block still uses k=2; next samples pass through.
- out_ready=0, k=0, 20 strobes, DEPTH=16 -> level=16, overflow=1, drop_cnt=4, and the head equals the 1st sample. Then pop with a push in the same cycle at full -> push accepted, level stays 16. Then clr_ovf -> overflow=0, drop_cnt=0.
- k=3, 5 samples then enable low for 1 cycle, then 8 samples of 0x40 -> exactly one result 0x40. Assert rst mid-block with 3 entries queued -> all outputs return to 0 immediately.
- PCM_CAPTURE_PEAK_EN defined, samples 0x12,0x80,0x33 -> peak=0x80; peak_clr with no sample -> 0; then 0x05 -> 0x05. With the macro undefined -> peak stays 0.
